// File: rtl/alu_multicycle.sv
// Multi-cycle ALU: single-cycle logic/arith ops, iterative shift-add multiply and optional
// restoring divide. Define ALU_MULTICYCLE_DIV_EN to build the divider; otherwise opcode 12 is undefined.
module alu_multicycle #(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic             Start,
   input  logic [3:0]       ALUControl,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             Busy,
   output logic             Done,
   output logic [WIDTH-1:0] ALUResult,
   output logic [WIDTH-1:0] Hi,
   output logic             Zero,
   output logic             DivByZero
);

   // state | meaning
   // IDLE  | waiting for Start
   // MUL   | shift-add multiply, one multiplier bit per cycle
   // DIV   | restoring divide, one quotient bit per cycle
   // FIN   | results valid, Done pulse
   typedef enum logic [1:0] {IDLE, MUL, DIV, FIN} state_t;

   localparam logic [3:0] OP_AND = 4'd0;
   localparam logic [3:0] OP_OR  = 4'd1;
   localparam logic [3:0] OP_ADD = 4'd2;
   localparam logic [3:0] OP_NOR = 4'd3;
   localparam logic [3:0] OP_SUB = 4'd6;
   localparam logic [3:0] OP_SLT = 4'd7;
   localparam logic [3:0] OP_MUL = 4'd9;
   localparam logic [3:0] OP_SLL = 4'd10;
   localparam logic [3:0] OP_SGT = 4'd11;
`ifdef ALU_MULTICYCLE_DIV_EN
   localparam logic [3:0] OP_DIV = 4'd12;
`endif

   state_t           state, state_nx;
   logic [SHW-1:0]   cnt;
   logic [WIDTH-1:0] opnd;
   logic [WIDTH-1:0] acc_hi, acc_lo;
   logic [WIDTH-1:0] single_res;
   logic             is_mul, div_go, div_zero;
   logic [WIDTH:0]   mul_sum;
   logic [WIDTH-1:0] mul_hi_nx, mul_lo_nx;

   assign is_mul = (ALUControl == OP_MUL);

`ifdef ALU_MULTICYCLE_DIV_EN
   logic [WIDTH:0]   div_shift, div_diff;
   logic             div_ok;
   logic [WIDTH-1:0] div_hi_nx, div_lo_nx;

   assign div_go   = (ALUControl == OP_DIV) && (B != '0);
   assign div_zero = (ALUControl == OP_DIV) && (B == '0);

   // Partial remainder stays below the divisor, so the sign of the W+1 bit difference decides the bit.
   assign div_shift = {acc_hi, acc_lo[WIDTH-1]};
   assign div_diff  = div_shift - {1'b0, opnd};
   assign div_ok    = ~div_diff[WIDTH];
   assign div_hi_nx = div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
   assign div_lo_nx = {acc_lo[WIDTH-2:0], div_ok};
`else
   assign div_go   = 1'b0;
   assign div_zero = 1'b0;
`endif

   // {acc_hi, acc_lo} holds partial product above the not-yet-consumed multiplier bits.
   assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
   assign mul_hi_nx = mul_sum[WIDTH:1];
   assign mul_lo_nx = {mul_sum[0], acc_lo[WIDTH-1:1]};

   always_comb begin
      single_res = '0;
      case (ALUControl)
         OP_AND:  single_res = A & B;
         OP_OR:   single_res = A | B;
         OP_ADD:  single_res = A + B;
         OP_NOR:  single_res = ~(A | B);
         OP_SUB:  single_res = A - B;
         OP_SLT:  single_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
         OP_SLL:  single_res = A << B[SHW-1:0];
         OP_SGT:  single_res = {{(WIDTH-1){1'b0}}, ($signed(A) > $signed(B))};
         default: single_res = '0;
      endcase
   end

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) state <= IDLE;
      else      state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      Busy     = 1'b0;
      Done     = 1'b0;
      case (state)
         IDLE: begin
            if (Start) begin
               if (is_mul)      state_nx = MUL;
               else if (div_go) state_nx = DIV;
               else             state_nx = FIN;
            end
         end
         MUL: begin
            Busy = 1'b1;
            if (cnt == '0) state_nx = FIN;
         end
         DIV: begin
            Busy = 1'b1;
            if (cnt == '0) state_nx = FIN;
         end
         FIN: begin
            Done     = 1'b1;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         cnt       <= '0;
         opnd      <= '0;
         acc_hi    <= '0;
         acc_lo    <= '0;
         ALUResult <= '0;
         Hi        <= '0;
         Zero      <= 1'b1;
         DivByZero <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (Start) begin
                  cnt    <= SHW'(WIDTH - 1);
                  acc_hi <= '0;
                  if (is_mul) begin
                     opnd   <= A;
                     acc_lo <= B;
                  end else if (div_go) begin
                     opnd   <= B;
                     acc_lo <= A;
                  end else if (div_zero) begin
                     ALUResult <= '1;
                     Hi        <= A;
                     Zero      <= 1'b0;
                     DivByZero <= 1'b1;
                  end else begin
                     ALUResult <= single_res;
                     Hi        <= '0;
                     Zero      <= (single_res == '0);
                     DivByZero <= 1'b0;
                  end
               end
            end
            MUL: begin
               acc_hi <= mul_hi_nx;
               acc_lo <= mul_lo_nx;
               cnt    <= cnt - 1'b1;
               if (cnt == '0) begin
                  ALUResult <= mul_lo_nx;
                  Hi        <= mul_hi_nx;
                  Zero      <= (mul_lo_nx == '0);
                  DivByZero <= 1'b0;
               end
            end
`ifdef ALU_MULTICYCLE_DIV_EN
            DIV: begin
               acc_hi <= div_hi_nx;
               acc_lo <= div_lo_nx;
               cnt    <= cnt - 1'b1;
               if (cnt == '0) begin
                  ALUResult <= div_lo_nx;
                  Hi        <= div_hi_nx;
                  Zero      <= (div_lo_nx == '0);
                  DivByZero <= 1'b0;
               end
            end
`endif
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_multicycle.sv
// Self-checking bench for alu_multicycle: cycle-level behavioural model compared every cycle,
// plus directed vectors with hand-computed results. Honours ALU_MULTICYCLE_DIV_EN.
module tb_alu_multicycle;
   localparam int W = 32;

   logic          Clk = 1'b0;
   logic          Rst;
   logic          Start;
   logic [3:0]    ALUControl;
   logic [W-1:0]  A, B;
   logic          Busy, Done;
   logic [W-1:0]  ALUResult, Hi;
   logic          Zero, DivByZero;

   int errors = 0;
   int checks = 0;
   int n, busy_n;

   alu_multicycle #(.WIDTH(W)) dut (
      .Clk(Clk), .Rst(Rst), .Start(Start), .ALUControl(ALUControl), .A(A), .B(B),
      .Busy(Busy), .Done(Done), .ALUResult(ALUResult), .Hi(Hi), .Zero(Zero), .DivByZero(DivByZero)
   );

   always #5 Clk = ~Clk;

   typedef struct packed {
      logic [W-1:0] res;
      logic [W-1:0] hi;
      logic         dbz;
      logic [7:0]   lat;
   } mres_t;

   function automatic mres_t model_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      mres_t m;
      logic [2*W-1:0] p;
      m = '0;
      case (op)
         4'd0:  m.res = a & b;
         4'd1:  m.res = a | b;
         4'd2:  m.res = a + b;
         4'd3:  m.res = ~(a | b);
         4'd6:  m.res = a - b;
         4'd7:  m.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         4'd9:  begin
            p = {32'd0, a} * {32'd0, b};
            m.res = p[W-1:0];
            m.hi  = p[2*W-1:W];
            m.lat = 8'(W);
         end
         4'd10: m.res = a << b[4:0];
         4'd11: m.res = ($signed(a) > $signed(b)) ? 32'd1 : 32'd0;
`ifdef ALU_MULTICYCLE_DIV_EN
         4'd12: begin
            if (b == '0) begin
               m.res = '1;
               m.hi  = a;
               m.dbz = 1'b1;
            end else begin
               m.res = a / b;
               m.hi  = a % b;
               m.lat = 8'(W);
            end
         end
`endif
         default: m = '0;
      endcase
      return m;
   endfunction

   // Model: outputs commit 'lat' cycles after acceptance; Done the cycle after commit.
   mres_t        now_res, pend;
   int           remain = 0;
   logic         exp_busy = 1'b0, exp_done = 1'b0, exp_zero = 1'b1, exp_dbz = 1'b0;
   logic [W-1:0] exp_res = '0, exp_hi = '0;

   assign now_res = model_op(ALUControl, A, B);

   always @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         remain   <= 0;
         pend     <= '0;
         exp_busy <= 1'b0;
         exp_done <= 1'b0;
         exp_res  <= '0;
         exp_hi   <= '0;
         exp_zero <= 1'b1;
         exp_dbz  <= 1'b0;
      end else begin
         exp_done <= 1'b0;
         if (remain > 0) begin
            remain <= remain - 1;
            if (remain == 1) begin
               exp_busy <= 1'b0;
               exp_done <= 1'b1;
               exp_res  <= pend.res;
               exp_hi   <= pend.hi;
               exp_zero <= (pend.res == '0);
               exp_dbz  <= pend.dbz;
            end
         end else if (!exp_busy && !exp_done && Start) begin
            if (now_res.lat == 8'd0) begin
               exp_done <= 1'b1;
               exp_res  <= now_res.res;
               exp_hi   <= now_res.hi;
               exp_zero <= (now_res.res == '0);
               exp_dbz  <= now_res.dbz;
            end else begin
               pend     <= now_res;
               remain   <= int'(now_res.lat);
               exp_busy <= 1'b1;
            end
         end
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge Clk) begin
      chk("busy",  64'(Busy),      64'(exp_busy));
      chk("done",  64'(Done),      64'(exp_done));
      chk("res",   64'(ALUResult), 64'(exp_res));
      chk("hi",    64'(Hi),        64'(exp_hi));
      chk("zero",  64'(Zero),      64'(exp_zero));
      chk("dbz",   64'(DivByZero), 64'(exp_dbz));
   end

   task automatic start_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      @(negedge Clk);
      ALUControl = op;
      A = a;
      B = b;
      Start = 1'b1;
      @(posedge Clk);
      #1;
      Start = 1'b0;
      A = $urandom;
      B = $urandom;
      ALUControl = 4'($urandom_range(0, 15));
      n = 0;
      busy_n = 0;
   endtask

   task automatic step();
      @(negedge Clk);
      n++;
      if (Busy) busy_n++;
   endtask

   task automatic wait_done();
      int guard = 0;
      do begin
         step();
         guard++;
      end while (!Done && guard < 100);
      chk("done_seen", 64'(Done), 64'(1));
   endtask

   task automatic run(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      start_op(op, a, b);
      wait_done();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      Rst = 1'b0;
      Start = 1'b0;
      ALUControl = 4'd0;
      A = '0;
      B = '0;
      repeat (3) @(negedge Clk);
      chk("rst_zero", 64'(Zero), 64'(1));
      chk("rst_res",  64'(ALUResult), 64'(0));
      #2 Rst = 1'b1;

      run(4'd2, 32'h7FFF_FFFF, 32'd1);
      chk("add_lat",  64'(n), 64'(1));
      chk("add_busy", 64'(busy_n), 64'(0));
      chk("add_res",  64'(ALUResult), 64'(32'h8000_0000));
      chk("add_zero", 64'(Zero), 64'(0));

      run(4'd7, 32'hFFFF_FFFF, 32'd1);
      chk("slt_res", 64'(ALUResult), 64'(1));
      run(4'd11, 32'hFFFF_FFFF, 32'd1);
      chk("sgt_res", 64'(ALUResult), 64'(0));
      run(4'd6, 32'd5, 32'd5);
      chk("sub_res",  64'(ALUResult), 64'(0));
      chk("sub_zero", 64'(Zero), 64'(1));

      run(4'd0, 32'h0000_F0F0, 32'h0000_FF00);
      chk("and_res", 64'(ALUResult), 64'(32'h0000_F000));
      run(4'd3, 32'd0, 32'd0);
      chk("nor_res", 64'(ALUResult), 64'(32'hFFFF_FFFF));
      run(4'd10, 32'd1, 32'h25);
      chk("sll_res", 64'(ALUResult), 64'(32'h20));

      run(4'd9, 32'hFFFF_FFFF, 32'd2);
      chk("mul_lat",  64'(n), 64'(33));
      chk("mul_busy", 64'(busy_n), 64'(32));
      chk("mul_hi",   64'(Hi), 64'(1));
      chk("mul_res",  64'(ALUResult), 64'(32'hFFFF_FFFE));

      run(4'd13, 32'd7, 32'd9);
      chk("undef_res", 64'(ALUResult), 64'(0));
      chk("undef_hi",  64'(Hi), 64'(0));

      run(4'd9, 32'h1234_5678, 32'h9ABC_DEF0);
      chk("mul2_lat", 64'(n), 64'(33));

      run(4'd12, 32'd100, 32'd7);
`ifdef ALU_MULTICYCLE_DIV_EN
      chk("div_lat", 64'(n), 64'(33));
      chk("div_res", 64'(ALUResult), 64'(14));
      chk("div_hi",  64'(Hi), 64'(2));
`else
      chk("div_lat", 64'(n), 64'(1));
      chk("div_res", 64'(ALUResult), 64'(0));
      chk("div_hi",  64'(Hi), 64'(0));
`endif
      chk("div_dbz", 64'(DivByZero), 64'(0));

      run(4'd12, 32'h1234, 32'd0);
      chk("dz_lat", 64'(n), 64'(1));
`ifdef ALU_MULTICYCLE_DIV_EN
      chk("dz_res", 64'(ALUResult), 64'(32'hFFFF_FFFF));
      chk("dz_hi",  64'(Hi), 64'(32'h1234));
      chk("dz_dbz", 64'(DivByZero), 64'(1));
`else
      chk("dz_res", 64'(ALUResult), 64'(0));
      chk("dz_dbz", 64'(DivByZero), 64'(0));
`endif
      run(4'd2, 32'd1, 32'd1);
      chk("dbz_clear", 64'(DivByZero), 64'(0));

      // Start during Busy must be ignored
      start_op(4'd9, 32'd3, 32'd5);
      repeat (5) step();
      ALUControl = 4'd2;
      A = 32'd1;
      B = 32'd1;
      Start = 1'b1;
      repeat (3) step();
      Start = 1'b0;
      wait_done();
      chk("ign_lat", 64'(n), 64'(33));
      chk("ign_res", 64'(ALUResult), 64'(15));
      chk("ign_hi",  64'(Hi), 64'(0));

      // Start held through FIN: ignored in FIN, accepted in the following IDLE cycle
      @(negedge Clk);
      ALUControl = 4'd2;
      A = 32'd1;
      B = 32'd2;
      Start = 1'b1;
      @(posedge Clk);
      #1;
      A = 32'd10;
      B = 32'd20;
      @(negedge Clk);
      chk("fin_done1", 64'(Done), 64'(1));
      chk("fin_res1",  64'(ALUResult), 64'(3));
      @(negedge Clk);
      chk("fin_done2", 64'(Done), 64'(0));
      chk("fin_res2",  64'(ALUResult), 64'(3));
      @(posedge Clk);
      #1 Start = 1'b0;
      @(negedge Clk);
      chk("fin_done3", 64'(Done), 64'(1));
      chk("fin_res3",  64'(ALUResult), 64'(30));

      // Reset during MUL cycle 10
      start_op(4'd9, 32'h0000_FFFF, 32'h0000_FFFF);
      repeat (10) step();
      chk("rmul_busy", 64'(busy_n), 64'(10));
      #2 Rst = 1'b0;
      #1;
      chk("rmul_b",   64'(Busy), 64'(0));
      chk("rmul_d",   64'(Done), 64'(0));
      chk("rmul_res", 64'(ALUResult), 64'(0));
      chk("rmul_hi",  64'(Hi), 64'(0));
      chk("rmul_z",   64'(Zero), 64'(1));
      chk("rmul_dbz", 64'(DivByZero), 64'(0));
      repeat (2) @(negedge Clk);
      #2 Rst = 1'b1;
      run(4'd1, 32'hF0, 32'h0F);
      chk("or_lat",  64'(n), 64'(1));
      chk("or_res",  64'(ALUResult), 64'(32'hFF));
      chk("or_zero", 64'(Zero), 64'(0));

      repeat (3) @(negedge Clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
